pifo_calendar_v0_2: RTL



---
 rtl/pifo_pkg.sv | 19 +
 rtl/pifo_calendar_atom_v0_2.sv | 67 ++++++
 rtl/pifo_calendar_v0_2.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pifo_pkg.sv
// Shared definitions for the PIFO calendar: drop-policy codes and the
// layout of one stored entry, kept as a flat bundle {valid, rank, addr}
// so that the rank and address widths can stay module parameters.
package pifo_pkg;

  localparam int PIFO_DROP_REJECT = 0;
  localparam int PIFO_DROP_EVICT  = 1;

  // Width of an occupancy counter that can hold 0..depth inclusive.
  function automatic int pifo_count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of one entry bundle: valid bit on top, then rank, then address.
  function automatic int pifo_entry_width(input int rankWidth, input int addrWidth);
    return 1 + rankWidth + addrWidth;
  endfunction

endpackage

// File: rtl/pifo_calendar_atom_v0_2.sv
// One slot of the shift-register PIFO. Each slot compares its own rank
// against the incoming rank and picks its next entry from itself, its
// head-side neighbour, its tail-side neighbour or the new entry, using
// only its own compare and its neighbours' compares.
module pifo_calendar_atom_v0_2
  import pifo_pkg::*;
#(
  parameter int RANK_WIDTH = 19,
  parameter int ADDR_WIDTH = 12,
  parameter bit IS_HEAD    = 1'b0
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              ins_i,
  input  logic                                              pop_i,
  input  logic [pifo_entry_width(RANK_WIDTH, ADDR_WIDTH)-1:0] head_entry_i,
  input  logic [pifo_entry_width(RANK_WIDTH, ADDR_WIDTH)-1:0] tail_entry_i,
  input  logic [pifo_entry_width(RANK_WIDTH, ADDR_WIDTH)-1:0] new_entry_i,
  input  logic                                              head_cmp_i,
  input  logic                                              tail_cmp_i,
  output logic [pifo_entry_width(RANK_WIDTH, ADDR_WIDTH)-1:0] entry_o,
  output logic                                              cmp_o
);

  localparam int EW = pifo_entry_width(RANK_WIDTH, ADDR_WIDTH);

  logic [EW-1:0] entry_q;
  logic [EW-1:0] entry_d;
  logic          cmp;

  // This slot sits at or ahead of the insert point when it holds a rank
  // no larger than the incoming one, so equal ranks stay in FIFO order.
  assign cmp = entry_q[EW-1] &
               (entry_q[RANK_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH] <=
                new_entry_i[RANK_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH]);

  // Select the next entry for this slot from the insert/pop combination.
  always_comb begin
    entry_d = entry_q;
    if (ins_i && pop_i) begin
      if (tail_cmp_i) begin
        entry_d = tail_entry_i;
      end else if (IS_HEAD || cmp) begin
        entry_d = new_entry_i;
      end
    end else if (ins_i) begin
      if (!cmp) begin
        entry_d = (IS_HEAD || head_cmp_i) ? new_entry_i : head_entry_i;
      end
    end else if (pop_i) begin
      entry_d = tail_entry_i;
    end
  end

  // Slot storage register; reset empties the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;
  assign cmp_o   = cmp;

endmodule

// File: rtl/pifo_calendar_v0_2.sv
// Push-in/first-out calendar queue: entries sorted ascending by rank,
// FIFO among equal ranks, with insert/pop handshakes, occupancy status
// and a selectable overflow policy that reports every discarded address.
module pifo_calendar_v0_2
  import pifo_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int RANK_WIDTH  = 19,
  parameter int ADDR_WIDTH  = 12,
  parameter int DROP_MODE   = 0,
  parameter int COUNT_WIDTH = pifo_count_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_axis_insert_valid,
  output logic                   s_axis_insert_ready,
  input  logic [RANK_WIDTH-1:0]  s_axis_insert_rank,
  input  logic [ADDR_WIDTH-1:0]  s_axis_insert_addr,
  output logic                   m_axis_pop_valid,
  input  logic                   m_axis_pop_ready,
  output logic [RANK_WIDTH-1:0]  m_axis_pop_rank,
  output logic [ADDR_WIDTH-1:0]  m_axis_pop_addr,
  output logic                   m_axis_drop_valid,
  output logic [ADDR_WIDTH-1:0]  m_axis_drop_addr,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int EW = pifo_entry_width(RANK_WIDTH, ADDR_WIDTH);

  logic [EW-1:0]          entry [DEPTH];
  logic [DEPTH-1:0]       cmp;
  logic [EW-1:0]          newEntry;
  logic                   insFire;
  logic                   popFire;
  logic                   dropEvent;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   dropValid_q, dropValid_d;
  logic [ADDR_WIDTH-1:0]  dropAddr_q, dropAddr_d;

  assign newEntry = {1'b1, s_axis_insert_rank, s_axis_insert_addr};

  assign o_full  = (count_q == COUNT_WIDTH'(DEPTH));
  assign o_empty = (count_q == '0);

  // In reject mode the ready depends only on occupancy, never on pop_ready.
  assign s_axis_insert_ready = (DROP_MODE == PIFO_DROP_EVICT) ? 1'b1 : ~o_full;

  assign insFire = s_axis_insert_valid & s_axis_insert_ready;
  assign popFire = m_axis_pop_valid & m_axis_pop_ready;

  // Only an insert into a full queue without a freeing pop discards something.
  assign dropEvent = insFire & ~popFire & o_full;

  for (genvar i = 0; i < DEPTH; i++) begin : gSlot
    logic [EW-1:0] headEntry;
    logic [EW-1:0] tailEntry;
    logic          headCmp;
    logic          tailCmp;

    if (i == 0) begin : gHeadEdge
      assign headEntry = '0;
      assign headCmp   = 1'b0;
    end else begin : gHeadLink
      assign headEntry = entry[i-1];
      assign headCmp   = cmp[i-1];
    end

    if (i == DEPTH - 1) begin : gTailEdge
      assign tailEntry = '0;
      assign tailCmp   = 1'b0;
    end else begin : gTailLink
      assign tailEntry = entry[i+1];
      assign tailCmp   = cmp[i+1];
    end

    pifo_calendar_atom_v0_2 #(
      .RANK_WIDTH (RANK_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .IS_HEAD    (i == 0)
    ) uAtom (
      .clk          (clk),
      .rst          (rst),
      .ins_i        (insFire),
      .pop_i        (popFire),
      .head_entry_i (headEntry),
      .tail_entry_i (tailEntry),
      .new_entry_i  (newEntry),
      .head_cmp_i   (headCmp),
      .tail_cmp_i   (tailCmp),
      .entry_o      (entry[i]),
      .cmp_o        (cmp[i])
    );
  end

  // Next occupancy and drop report; a rank at or beyond the tail drops the
  // newcomer, otherwise the old tail is pushed out.
  always_comb begin
    count_d     = count_q;
    dropValid_d = 1'b0;
    dropAddr_d  = '0;
    if (insFire && !popFire && !dropEvent) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end else if (popFire && !insFire) begin
      count_d = count_q - COUNT_WIDTH'(1);
    end
    if (dropEvent) begin
      dropValid_d = 1'b1;
      dropAddr_d  = cmp[DEPTH-1] ? s_axis_insert_addr : entry[DEPTH-1][ADDR_WIDTH-1:0];
    end
  end

  // Status and drop-port registers; reset discards everything silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      dropValid_q <= 1'b0;
      dropAddr_q  <= '0;
    end else begin
      count_q     <= count_d;
      dropValid_q <= dropValid_d;
      dropAddr_q  <= dropAddr_d;
    end
  end

  assign o_count           = count_q;
  assign m_axis_drop_valid = dropValid_q;
  assign m_axis_drop_addr  = dropAddr_q;
  assign m_axis_pop_valid  = entry[0][EW-1];
  assign m_axis_pop_rank   = entry[0][RANK_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
  assign m_axis_pop_addr   = entry[0][ADDR_WIDTH-1:0];

endmodule
